payload_packet_buffer: RTL and testbench

- Store-and-forward packet buffer directly downstream of payload_aligner.
- Accepts aligned 64-bit payload beats plus the per-packet headers_t bundle. Releases a packet to the consumer only after its eop beat has been written.
- Presents packets on a valid/ready stream with headers held stable for the whole packet.
- Drops packets that do not fit, and packets that are malformed, instead of stalling the aligner (the aligner has no backpressure input).

---
 rtl/payload_packet_buffer.sv | 209 ++++++++++++++++++++
 tb/tb_payload_packet_buffer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/payload_packet_buffer.sv
// payload_packet_buffer: store-and-forward buffer releasing whole packets from payload_aligner
package payload_packet_buffer_pkg;
    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [15:0] eth_type;
    } headers_t;
endpackage

module payload_packet_buffer
    import payload_packet_buffer_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int MAX_PKTS = 8,
    parameter int CNT_W    = 16
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic             iValid,
    input  logic [63:0]      iPayload,
    input  headers_t         iHeaders,
    input  logic             iSop,
    input  logic             iEop,
    input  logic [7:0]       iByte_enable,
    output logic             oValid,
    input  logic             iReady,
    output logic [63:0]      oPayload,
    output headers_t         oHeaders,
    output logic             oSop,
    output logic             oEop,
    output logic [7:0]       oByte_enable,
    output logic [CNT_W-1:0] oDrop_count,
    output logic [CNT_W-1:0] oMalformed_count,
    output logic [CNT_W-1:0] oPkt_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int HA = $clog2(MAX_PKTS);
    localparam int HW = HA + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [HW-1:0] MAXP_P  = HW'(MAX_PKTS);

    typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;
    typedef struct packed {
        headers_t        hdr;
        logic [AW-1:0]   start;
        logic [PW-1:0]   len;
    } desc_t;

    logic [63:0] pay_mem [DEPTH];
    logic [7:0]  be_mem [DEPTH];
    desc_t       desc_mem [MAX_PKTS];

    state_t           state_q, state_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, cw_ptr_q, cw_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    len_q, len_d, beat_q, beat_d;
    logic [AW-1:0]    start_q, start_d, waddr, raddr;
    logic [HW-1:0]    hw_q, hw_d, hr_q, hr_d, hf_q, hf_d;
    headers_t         hdr_q, hdr_d, out_hdr_q, out_hdr_d;
    logic             out_valid_q, out_valid_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d;
    logic [63:0]      out_pay_q, out_pay_d;
    logic [7:0]       out_be_q, out_be_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d, mal_cnt_q, mal_cnt_d, pkt_cnt_q, pkt_cnt_d;
    logic             we, push, drop_inc, mal_inc, hs, ld, last;
    desc_t            push_desc, cur;

    // write FSM: a sop restarts from the committed pointer, so aborted packets vanish
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        cw_ptr_d  = cw_ptr_q;
        hdr_d     = hdr_q;
        start_d   = start_q;
        len_d     = len_q;
        we        = 1'b0;
        waddr     = wr_ptr_q[AW-1:0];
        push      = 1'b0;
        push_desc = '{hdr: hdr_q, start: start_q, len: len_q + PW'(1)};
        drop_inc  = 1'b0;
        mal_inc   = 1'b0;
        if (iValid) begin
            if (iSop) begin
                mal_inc  = (state_q == WRITE);
                wr_ptr_d = cw_ptr_q;
                if ((hw_q - hr_q) == MAXP_P || (cw_ptr_q - rd_ptr_q) == DEPTH_P) begin
                    drop_inc = 1'b1;
                    state_d  = iEop ? IDLE : DROP;
                end else begin
                    we        = 1'b1;
                    waddr     = cw_ptr_q[AW-1:0];
                    wr_ptr_d  = cw_ptr_q + PW'(1);
                    hdr_d     = iHeaders;
                    start_d   = cw_ptr_q[AW-1:0];
                    len_d     = PW'(1);
                    push      = iEop;
                    push_desc = '{hdr: iHeaders, start: cw_ptr_q[AW-1:0], len: PW'(1)};
                    cw_ptr_d  = iEop ? wr_ptr_d : cw_ptr_q;
                    state_d   = iEop ? IDLE : WRITE;
                end
            end else if (state_q == WRITE) begin
                if ((wr_ptr_q - rd_ptr_q) == DEPTH_P) begin
                    wr_ptr_d = cw_ptr_q;
                    drop_inc = 1'b1;
                    state_d  = iEop ? IDLE : DROP;
                end else begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    len_d    = len_q + PW'(1);
                    push     = iEop;
                    cw_ptr_d = iEop ? wr_ptr_d : cw_ptr_q;
                    state_d  = iEop ? IDLE : WRITE;
                end
            end else if (state_q == DROP) begin
                state_d = iEop ? IDLE : DROP;
            end else begin
                mal_inc = 1'b1;
            end
        end
        hw_d = hw_q + HW'(push);
    end

    // read side: output register prefetches committed beats; words free only on handshake
    always_comb begin
        cur         = desc_mem[hf_q[HA-1:0]];
        raddr       = cur.start + beat_q[AW-1:0];
        last        = beat_q == cur.len - PW'(1);
        hs          = out_valid_q && iReady;
        ld          = (!out_valid_q || iReady) && hf_q != hw_q;
        out_valid_d = ld ? 1'b1 : out_valid_q && !hs;
        out_pay_d   = ld ? pay_mem[raddr] : out_pay_q;
        out_be_d    = ld ? be_mem[raddr] : out_be_q;
        out_hdr_d   = ld ? cur.hdr : out_hdr_q;
        out_sop_d   = ld ? beat_q == '0 : out_sop_q;
        out_eop_d   = ld ? last : out_eop_q;
        beat_d      = ld ? (last ? '0 : beat_q + PW'(1)) : beat_q;
        hf_d        = hf_q + HW'(ld && last);
        hr_d        = hr_q + HW'(hs && out_eop_q);
        rd_ptr_d    = rd_ptr_q + PW'(hs);
        drop_cnt_d  = drop_cnt_q + CNT_W'(drop_inc && !(&drop_cnt_q));
        mal_cnt_d   = mal_cnt_q + CNT_W'(mal_inc && !(&mal_cnt_q));
        pkt_cnt_d   = pkt_cnt_q + CNT_W'(hs && out_eop_q && !(&pkt_cnt_q));
    end

    // payload/byte-enable storage and descriptor FIFO memories
    always_ff @(posedge iClk) begin
        if (we) begin
            pay_mem[waddr] <= iPayload;
            be_mem[waddr]  <= iEop ? iByte_enable : 8'hFF;
        end
        if (push) desc_mem[hw_q[HA-1:0]] <= push_desc;
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge iClk) begin
        if (!iReset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            cw_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            start_q     <= '0;
            hw_q        <= '0;
            hr_q        <= '0;
            hf_q        <= '0;
            hdr_q       <= '0;
            out_hdr_q   <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_pay_q   <= '0;
            out_be_q    <= '0;
            drop_cnt_q  <= '0;
            mal_cnt_q   <= '0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cw_ptr_q    <= cw_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            start_q     <= start_d;
            hw_q        <= hw_d;
            hr_q        <= hr_d;
            hf_q        <= hf_d;
            hdr_q       <= hdr_d;
            out_hdr_q   <= out_hdr_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_pay_q   <= out_pay_d;
            out_be_q    <= out_be_d;
            drop_cnt_q  <= drop_cnt_d;
            mal_cnt_q   <= mal_cnt_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    assign oValid           = out_valid_q;
    assign oPayload         = out_pay_q;
    assign oHeaders         = out_hdr_q;
    assign oSop             = out_sop_q;
    assign oEop             = out_eop_q;
    assign oByte_enable     = out_be_q;
    assign oDrop_count      = drop_cnt_q;
    assign oMalformed_count = mal_cnt_q;
    assign oPkt_count       = pkt_cnt_q;
endmodule

// File: tb/tb_payload_packet_buffer.sv
// tb_payload_packet_buffer: scoreboard bench for payload_packet_buffer
module tb_payload_packet_buffer;
    import payload_packet_buffer_pkg::*;

    typedef struct packed {
        logic [63:0] pay;
        headers_t    hdr;
        logic        sop;
        logic        eop;
        logic [7:0]  be;
    } beat_t;

    logic        iClk = 1'b0, iReset = 1'b0, iValid = 1'b0, iSop = 1'b0, iEop = 1'b0, iReady = 1'b0;
    logic [63:0] iPayload = '0;
    headers_t    iHeaders = '0;
    logic [7:0]  iByte_enable = '0;
    logic        oValid, oSop, oEop;
    logic [63:0] oPayload;
    headers_t    oHeaders;
    logic [7:0]  oByte_enable;
    logic [15:0] oDrop_count, oMalformed_count, oPkt_count;

    beat_t exp_q[$];
    beat_t mon_e, mon_a;
    int    checks = 0, failures = 0;
    bit    rtog = 1'b0;

    payload_packet_buffer #(.DEPTH(64), .MAX_PKTS(8), .CNT_W(16)) dut (
        .iClk(iClk), .iReset(iReset), .iValid(iValid), .iPayload(iPayload),
        .iHeaders(iHeaders), .iSop(iSop), .iEop(iEop), .iByte_enable(iByte_enable),
        .oValid(oValid), .iReady(iReady), .oPayload(oPayload), .oHeaders(oHeaders),
        .oSop(oSop), .oEop(oEop), .oByte_enable(oByte_enable),
        .oDrop_count(oDrop_count), .oMalformed_count(oMalformed_count), .oPkt_count(oPkt_count)
    );

    always #5 iClk = ~iClk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    always @(posedge iClk) begin
        if (rtog) begin
            #1;
            iReady = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge iClk) begin
        if (iReset && oValid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat: pay=%h sop=%b eop=%b, required no output", oPayload, oSop, oEop);
            end else begin
                mon_e = exp_q[0];
                mon_a = {oPayload, oHeaders, oSop, oEop, oByte_enable};
                if (mon_a !== mon_e)
                    begin
                        failures++;
                        $display("FAIL beat: got pay=%h hdr=%h sop=%b eop=%b be=%h, required pay=%h hdr=%h sop=%b eop=%b be=%h",
                                 mon_a.pay, mon_a.hdr, mon_a.sop, mon_a.eop, mon_a.be,
                                 mon_e.pay, mon_e.hdr, mon_e.sop, mon_e.eop, mon_e.be);
                    end
                if (iReady) void'(exp_q.pop_front());
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    function automatic headers_t mk_hdr(input int k);
        return '{dst_mac: 48'h0200_0000_0000 + 48'(k), src_mac: 48'h0600_0000_0000 + 48'(k * 7),
                 eth_type: 16'h0800 + 16'(k)};
    endfunction

    task automatic drive(input logic s, input logic e, input logic [63:0] p, input headers_t h, input logic [7:0] b);
        iValid = 1'b1;
        iSop = s;
        iEop = e;
        iPayload = p;
        iHeaders = h;
        iByte_enable = b;
        @(posedge iClk);
        #1;
        iValid = 1'b0;
        iSop = 1'b0;
        iEop = 1'b0;
    endtask

    task automatic send_pkt(input int n, input int k, input logic [7:0] b, input bit keep);
        headers_t    h, hj;
        logic [63:0] p;
        h = mk_hdr(k);
        hj = ~h;
        for (int i = 0; i < n; i++) begin
            p = {$urandom(), 32'(k * 256 + i)};
            if (keep) exp_q.push_back('{p, h, i == 0, i == n - 1, (i == n - 1) ? b : 8'hFF});
            drive(i == 0, i == n - 1, p, (i == 0) ? h : hj, (i == n - 1) ? b : 8'h5A);
        end
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge iClk);
            n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d beats left, required 0", nm, exp_q.size());
        end
        repeat (2) @(posedge iClk);
        #1;
    endtask

    initial begin
        int lens[6] = '{1, 6, 3, 8, 2, 5};
        logic [7:0] bes[6] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'hFF};
        int cnt;
        repeat (3) @(posedge iClk);
        #1;
        chk("reset_valid", 128'(oValid), 128'(0));
        chk("reset_payload", 128'(oPayload), 128'(0));
        chk("reset_headers", 128'(oHeaders), 128'(0));
        chk("reset_counters", 128'({oDrop_count, oMalformed_count, oPkt_count}), 128'(0));
        iReset = 1'b1;
        iReady = 1'b1;
        @(posedge iClk);
        #1;

        for (int k = 0; k < 100; k++) send_pkt(5, k, 8'(k), 1'b1);
        wait_drain("stream");
        chk("stream_pkt_count", 128'(oPkt_count), 128'(100));
        chk("stream_drop", 128'(oDrop_count), 128'(0));
        chk("stream_malformed", 128'(oMalformed_count), 128'(0));

        send_pkt(1, 150, 8'h3C, 1'b1);
        chk("latency_no_early_valid", 128'(oValid), 128'(0));
        @(posedge iClk);
        #1;
        chk("latency_valid_sop", 128'({oValid, oSop, oEop}), 128'(3'b111));
        wait_drain("latency");

        iReady = 1'b0;
        for (int k = 0; k < 4; k++) send_pkt(15, 200 + k, 8'h07, 1'b1);
        send_pkt(15, 204, 8'h07, 1'b0);
        chk("storage_full_drop", 128'(oDrop_count), 128'(1));
        iReady = 1'b1;
        wait_drain("storage_full");
        chk("storage_full_pkt_count", 128'(oPkt_count), 128'(105));

        iReady = 1'b0;
        for (int k = 0; k < 9; k++) send_pkt(1, 220 + k, 8'h80 >> k, k < 8);
        repeat (2) @(posedge iClk);
        #1;
        chk("fifo_full_drop", 128'(oDrop_count), 128'(2));
        iReady = 1'b1;
        cnt = 0;
        repeat (8) begin
            if (oValid) cnt++;
            @(posedge iClk);
            #1;
        end
        chk("fifo_drain_consecutive", 128'(cnt), 128'(8));
        chk("fifo_drain_idle_after", 128'(oValid), 128'(0));
        wait_drain("fifo_full");
        chk("fifo_full_pkt_count", 128'(oPkt_count), 128'(113));

        drive(1'b1, 1'b0, 64'h1111, mk_hdr(240), 8'h00);
        drive(1'b0, 1'b0, 64'h2222, mk_hdr(0), 8'h00);
        drive(1'b0, 1'b0, 64'h3333, mk_hdr(0), 8'h00);
        send_pkt(3, 241, 8'h0F, 1'b1);
        wait_drain("malformed");
        chk("malformed_count", 128'(oMalformed_count), 128'(1));
        chk("malformed_pkt_count", 128'(oPkt_count), 128'(114));
        drive(1'b0, 1'b0, 64'h4444, mk_hdr(0), 8'h00);
        repeat (3) @(posedge iClk);
        #1;
        chk("stray_beat_malformed", 128'(oMalformed_count), 128'(2));
        chk("stray_beat_no_output", 128'(oValid), 128'(0));

        rtog = 1'b1;
        for (int k = 0; k < 6; k++) send_pkt(lens[k], 260 + k, bes[k], 1'b1);
        wait_drain("ready_toggle");
        rtog = 1'b0;
        @(posedge iClk);
        #2;
        iReady = 1'b1;
        chk("ready_toggle_pkt_count", 128'(oPkt_count), 128'(120));
        chk("ready_toggle_drop", 128'(oDrop_count), 128'(2));

        iReady = 1'b0;
        send_pkt(4, 300, 8'h0F, 1'b1);
        drive(1'b1, 1'b0, 64'h5555, mk_hdr(301), 8'h00);
        drive(1'b0, 1'b0, 64'h6666, mk_hdr(0), 8'h00);
        iReset = 1'b0;
        exp_q.delete();
        @(posedge iClk);
        #1;
        chk("midreset_outputs", 128'({oValid, oSop, oEop, oByte_enable}), 128'(0));
        chk("midreset_payload", 128'(oPayload), 128'(0));
        chk("midreset_headers", 128'(oHeaders), 128'(0));
        chk("midreset_counters", 128'({oDrop_count, oMalformed_count, oPkt_count}), 128'(0));
        iReset = 1'b1;
        iReady = 1'b1;
        send_pkt(3, 310, 8'h01, 1'b1);
        wait_drain("post_reset");
        chk("post_reset_pkt_count", 128'(oPkt_count), 128'(1));
        chk("post_reset_drop_mal", 128'({oDrop_count, oMalformed_count}), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
